mbtrain_sb_tx_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single sideband TX message path between MBTRAIN requesters.

---
 rtl/mbtrain_sb_tx_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mbtrain_sb_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbtrain_sb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mbtrain_sb_tx_arbiter
//
// Round-robin arbiter that shares the single sideband TX message path between
// the MBTRAIN substate FSMs. One requester owns the path at a time: its message
// code is latched at grant and presented with o_valid until the serializer
// reports busy, and ownership is held until that busy falls.
//
// Ports
//   clk                 clock
//   rst_n               async reset, active low
//   i_en                block enable; low flushes the arbiter to IDLE
//   i_req               per-requester request level, held until o_done
//   i_msg               flat message codes, requester k at [k*MSG_W +: MSG_W]
//   i_busy              sideband serializer busy
//   o_sideband_message  latched message code of the current/last owner
//   o_valid             message valid toward the sideband encoder
//   o_grant             one-hot current owner, 0 when idle
//   o_done              1-cycle pulse, owner's message fully sent
//   o_timeout           1-cycle pulse on watchdog abort
//
// Build option
//   MBTRAIN_ARB_TIMEOUT_EN  enables the TIMEOUT_CYCLES ownership watchdog;
//                           without it o_timeout is tied 0 and the arbiter
//                           waits on the serializer indefinitely.
//
// State table
//   state | meaning
//   IDLE  | no owner; grant the next requester when the path is quiet
//   SEND  | o_valid high, waiting for the serializer to take the message
//   WAIT  | serializer busy with the message, waiting for busy to fall
// -----------------------------------------------------------------------------
module mbtrain_sb_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int MSG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_en,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*MSG_W-1:0]   i_msg,
    input  logic                       i_busy,
    output logic [MSG_W-1:0]           o_sideband_message,
    output logic                       o_valid,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [NUM_REQ-1:0]         o_done,
    output logic                       o_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic               busy_q;
    logic               busy_fall;
    logic               tmo_abort;

    logic               found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     cand;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   next_ptr;
    logic [MSG_W-1:0]   msg_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_msg
        assign msg_arr[k] = i_msg[k*MSG_W +: MSG_W];
    end

    assign busy_fall = busy_q & ~i_busy;

    // Scan ptr, ptr+1, ... with an explicit wrap so a non power-of-two
    // NUM_REQ never produces an out-of-range candidate.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && i_req[cand[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;
    assign next_ptr   = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

`ifdef MBTRAIN_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_abort = (state != ST_IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter is zero on the grant edge (state still IDLE) and then counts
    // every SEND/WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= i_en && tmo_abort;
            if (!i_en || state == ST_IDLE || tmo_abort) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Keeps TIMEOUT_CYCLES referenced when the watchdog is not built.
    logic unused_timeout_cfg;

    assign tmo_abort          = 1'b0;
    assign o_timeout          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            ptr                <= '0;
            owner              <= '0;
            busy_q             <= 1'b0;
            o_sideband_message <= '0;
            o_valid            <= 1'b0;
            o_grant            <= '0;
            o_done             <= '0;
        end else begin
            busy_q <= i_busy;
            o_done <= '0;
            if (!i_en) begin
                // ptr and the latched message survive a flush.
                state   <= ST_IDLE;
                o_valid <= 1'b0;
                o_grant <= '0;
            end else if (tmo_abort) begin
                state   <= ST_IDLE;
                o_valid <= 1'b0;
                o_grant <= '0;
                ptr     <= next_ptr;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Foreign traffic on the serializer blocks new grants.
                        if (found && !i_busy) begin
                            owner              <= win_idx;
                            o_grant            <= win_onehot;
                            o_sideband_message <= msg_arr[win_idx];
                            o_valid            <= 1'b1;
                            state              <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (i_busy) begin
                            o_valid <= 1'b0;
                            state   <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (busy_fall) begin
                            o_done  <= o_grant;
                            o_grant <= '0;
                            ptr     <= next_ptr;
                            state   <= ST_IDLE;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        o_valid <= 1'b0;
                        o_grant <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mbtrain_sb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mbtrain_sb_tx_arbiter
//
// Scoreboard bench for mbtrain_sb_tx_arbiter (NUM_REQ=2, MSG_W=4,
// TIMEOUT_CYCLES=16). Expected grants/messages and done pulses are queued as
// stimulus is driven; a negedge monitor pops and compares them as the DUT
// produces them. Directed checks cover latency, flush, reset and stability.
// The watchdog scenario is included when MBTRAIN_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mbtrain_sb_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int MSG_W   = 4;

    logic                     clk    = 1'b0;
    logic                     rst_n  = 1'b0;
    logic                     i_en   = 1'b0;
    logic                     i_busy = 1'b0;
    logic [NUM_REQ-1:0]       i_req  = '0;
    logic [NUM_REQ*MSG_W-1:0] i_msg  = '0;
    logic [MSG_W-1:0]         o_sideband_message;
    logic                     o_valid;
    logic [NUM_REQ-1:0]       o_grant;
    logic [NUM_REQ-1:0]       o_done;
    logic                     o_timeout;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [NUM_REQ-1:0] grant;
        logic [MSG_W-1:0]   msg;
    } exp_t;

    exp_t               exp_q[$];
    logic [NUM_REQ-1:0] done_q[$];

    always #5 clk = ~clk;

    mbtrain_sb_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .MSG_W          (MSG_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_en               (i_en),
        .i_req              (i_req),
        .i_msg              (i_msg),
        .i_busy             (i_busy),
        .o_sideband_message (o_sideband_message),
        .o_valid            (o_valid),
        .o_grant            (o_grant),
        .o_done             (o_done),
        .o_timeout          (o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: grant/message at each new o_valid, done pulses, held message.
    logic             valid_prev = 1'b0;
    logic             in_xfer    = 1'b0;
    logic [MSG_W-1:0] cur_msg    = '0;
    exp_t             mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && !valid_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_grant", 32'(o_grant), 32'd0);
                    in_xfer = 1'b0;
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_grant", 32'(o_grant), 32'(mon_e.grant));
                    chk("sb_msg", 32'(o_sideband_message), 32'(mon_e.msg));
                    cur_msg = mon_e.msg;
                    in_xfer = 1'b1;
                end
            end
            if (o_grant == '0) begin
                in_xfer = 1'b0;
            end else if (in_xfer) begin
                chk("msg_hold", 32'(o_sideband_message), 32'(cur_msg));
            end
            if (o_done != '0) begin
                if (done_q.size() == 0) begin
                    chk("unexp_done", 32'(o_done), 32'd0);
                end else begin
                    chk("sb_done", 32'(o_done), 32'(done_q.pop_front()));
                end
            end
            valid_prev = o_valid;
        end else begin
            valid_prev = 1'b0;
            in_xfer    = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!o_valid && i < 60) begin
            tick();
            i++;
        end
        if (!o_valid) chk(tag, 32'(o_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (o_done == '0 && i < 60) begin
            tick();
            i++;
        end
        if (o_done == '0) chk(tag, 32'(o_done != '0), 32'd1);
    endtask

    // Serializer model: busy rises 'rise' cycles after o_valid is seen and
    // stays high for 'len' cycles.
    task automatic serve(input int rise, input int len, input string tag);
        wait_valid({tag, "_valid_to"});
        repeat (rise) tick();
        i_busy = 1'b1;
        repeat (len) tick();
        i_busy = 1'b0;
        wait_done({tag, "_done_to"});
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_msg", 32'(o_sideband_message), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        rst_n = 1'b1;
        i_en  = 1'b1;
        tick();

        // T1: single requester, exact cycle timing.
        i_msg = 8'h0A;
        i_req = 2'b01;
        exp_q.push_back('{grant: 2'b01, msg: 4'hA});
        done_q.push_back(2'b01);
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk("t1_valid", 32'(o_valid), 32'd1);
            chk("t1_grant", 32'(o_grant), 32'd1);
            chk("t1_msg", 32'(o_sideband_message), 32'hA);
            if (c == 3) i_busy = 1'b1;
            tick();
        end
        chk("t1_valid_drop", 32'(o_valid), 32'd0);
        chk("t1_grant_held", 32'(o_grant), 32'd1);
        repeat (4) tick();
        i_busy = 1'b0;
        chk("t1_no_early_done", 32'(o_done), 32'd0);
        tick();
        chk("t1_done", 32'(o_done), 32'd1);
        chk("t1_grant_clr", 32'(o_grant), 32'd0);
        i_req = 2'b00;
        tick();
        chk("t1_done_pulse", 32'(o_done), 32'd0);
        chk("t1_idle_valid", 32'(o_valid), 32'd0);

        // T2: contention from reset, round-robin order 0,1,0.
        rst_n = 1'b0;
        i_msg = 8'h53;
        i_req = 2'b11;
        repeat (2) tick();
        exp_q.push_back('{grant: 2'b01, msg: 4'h3});
        exp_q.push_back('{grant: 2'b10, msg: 4'h5});
        exp_q.push_back('{grant: 2'b01, msg: 4'h3});
        done_q.push_back(2'b01);
        done_q.push_back(2'b10);
        done_q.push_back(2'b01);
        rst_n = 1'b1;
        tick();
        chk("t2_first_grant", 32'(o_grant), 32'd1);
        serve(1, 2, "t2a");
        serve(1, 2, "t2b");
        serve(1, 2, "t2c");
        i_req = 2'b00;
        tick();

        // T5: single requester 0 with ptr at 1; message change after grant ignored.
        i_msg = 8'h01;
        i_req = 2'b01;
        exp_q.push_back('{grant: 2'b01, msg: 4'h1});
        done_q.push_back(2'b01);
        tick();
        chk("t5_grant", 32'(o_grant), 32'd1);
        i_msg = 8'h0F;
        serve(2, 3, "t5");
        chk("t5_msg_kept", 32'(o_sideband_message), 32'h1);
        i_req = 2'b00;
        tick();

        // T3: busy already high before the request.
        i_busy = 1'b1;
        i_msg  = 8'h60;
        i_req  = 2'b10;
        exp_q.push_back('{grant: 2'b10, msg: 4'h6});
        done_q.push_back(2'b10);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t3_no_valid", 32'(o_valid), 32'd0);
        end
        i_busy = 1'b0;
        tick();
        chk("t3_grant", 32'(o_grant), 32'h2);
        chk("t3_valid", 32'(o_valid), 32'd1);
        serve(1, 2, "t3");
        i_req = 2'b00;
        tick();

        // T4: flush with i_en low during WAIT; ptr must survive the flush.
        i_msg = 8'h07;
        i_req = 2'b01;
        exp_q.push_back('{grant: 2'b01, msg: 4'h7});
        wait_valid("t4_valid_to");
        tick();
        i_busy = 1'b1;
        repeat (2) tick();
        chk("t4_in_wait", 32'(o_grant), 32'd1);
        i_en  = 1'b0;
        i_req = 2'b00;
        tick();
        chk("t4_flush_grant", 32'(o_grant), 32'd0);
        chk("t4_flush_valid", 32'(o_valid), 32'd0);
        i_busy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_no_done", 32'(o_done), 32'd0);
        end
        i_en  = 1'b1;
        i_msg = 8'h97;
        i_req = 2'b11;
        exp_q.push_back('{grant: 2'b01, msg: 4'h7});
        exp_q.push_back('{grant: 2'b10, msg: 4'h9});
        done_q.push_back(2'b01);
        done_q.push_back(2'b10);
        serve(0, 2, "t4a");
        serve(0, 2, "t4b");
        i_req = 2'b00;
        tick();

        // T4b: reset asserted during SEND clears outputs immediately.
        i_msg = 8'h04;
        i_req = 2'b01;
        exp_q.push_back('{grant: 2'b01, msg: 4'h4});
        wait_valid("t4b_valid_to");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4b_valid", 32'(o_valid), 32'd0);
        chk("t4b_grant", 32'(o_grant), 32'd0);
        chk("t4b_msg", 32'(o_sideband_message), 32'd0);
        i_req = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t4b_done", 32'(o_done), 32'd0);

`ifdef MBTRAIN_ARB_TIMEOUT_EN
        // T6: busy never rises; watchdog aborts 16 cycles after grant.
        i_msg = 8'hCB;
        i_req = 2'b11;
        exp_q.push_back('{grant: 2'b01, msg: 4'hB});
        exp_q.push_back('{grant: 2'b10, msg: 4'hC});
        done_q.push_back(2'b10);
        wait_valid("t6_valid_to");
        repeat (15) tick();
        chk("t6_pre_timeout", 32'(o_timeout), 32'd0);
        chk("t6_pre_valid", 32'(o_valid), 32'd1);
        tick();
        chk("t6_timeout", 32'(o_timeout), 32'd1);
        chk("t6_valid", 32'(o_valid), 32'd0);
        chk("t6_grant", 32'(o_grant), 32'd0);
        tick();
        chk("t6_timeout_pulse", 32'(o_timeout), 32'd0);
        chk("t6_next_grant", 32'(o_grant), 32'h2);
        serve(0, 2, "t6");
        i_req = 2'b00;
        tick();
`endif

        repeat (3) tick();
        chk("sb_empty", 32'(exp_q.size() + done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
